dec_param_enable: RTL and testbench
===================================

DEC_PARAM_ENABLE -- requirements
Module: dec_param_enable

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset.
REQ-002 Parameter N, default 2, SHALL set the select width; legal range 1..8.
REQ-003 Parameter W SHALL equal 2**N, is derived, and SHALL NOT be overridden; it sets the decoded output width.
REQ-004 Port clk, input, 1 bit: rising-edge clock for all registered state.
REQ-005 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 Port in, input, N bits: binary select index.
REQ-007 Port enable, input, 1 bit: decoder enable, active high.
REQ-008 Port d, output, W bits: combinational one-hot decode.
REQ-009 Port d_q, output, W bits: registered copy of d.
REQ-010 Port valid_q, output, 1 bit: registered copy of enable.
REQ-011 Port sel_q, output, N bits: last index decoded while enabled.
REQ-012 Port hit_cnt, output, 16 bits: count of enabled cycles.

Function
REQ-013 d[k] SHALL be 1 if and only if enable=1 and in=k, for every k in 0..W-1.
REQ-014 When enable=1, d SHALL be exactly one-hot.
REQ-015 When enable=0, d SHALL be all zeros regardless of in.
REQ-016 d SHALL be purely combinational, independent of clk and rst_n, and settle within 1 ns of a change on in or enable.
REQ-017 d SHALL contain no latches; X or Z on an input is don't-care.
REQ-018 On each rising clk edge with rst_n=1, d_q SHALL load the current d and valid_q SHALL load enable; latency is 1 cycle.
REQ-019 On a rising edge with rst_n=1 and enable=1, sel_q SHALL load in; with enable=0, sel_q SHALL hold its value.
REQ-020 On a rising edge with rst_n=1 and enable=1, hit_cnt SHALL increment by 1, saturating at 16'hFFFF with no wrap-around.
REQ-021 With enable=0, hit_cnt SHALL hold its value.
REQ-022 When in changes and enable toggles between the same two edges, only the values sampled at the edge SHALL matter.
REQ-023 d_q SHALL always equal the one-hot decode of sel_q when valid_q=1, and SHALL be zero when valid_q=0.

Reset
REQ-024 When rst_n=0 at a rising edge, d_q SHALL clear to 0, valid_q to 0, sel_q to 0 and hit_cnt to 0.
REQ-025 Reset SHALL take priority over every update rule, including when enable=1 in the same cycle.
REQ-026 Reset SHALL NOT affect d, which keeps following in and enable during reset.
REQ-027 Reset applied mid-operation SHALL take effect on the next rising edge only; there is no asynchronous clear.

Verification (N=2)
REQ-028 Sweep all 8 values of {enable,in} with 1 ns settle after each -> d = 0000 for enable=0; d = 0001, 0010, 0100, 1000 for in = 0, 1, 2, 3 with enable=1.
REQ-029 Hold rst_n=0 for 2 cycles, then apply enable=1, in=2 for one cycle -> the next edge gives d_q=0100, valid_q=1, sel_q=2, hit_cnt=1.
REQ-030 Run enable=1 with in=3 for 5 cycles, then enable=0, in=1 for 3 cycles -> hit_cnt=5, sel_q=3, d_q=0000, valid_q=0, d=0000.
REQ-031 Assert rst_n=0 together with enable=1, in=1 -> after the edge all registered outputs are 0 while d=0010.
REQ-032 Preload or run the counter to hit_cnt=16'hFFFE, then hold enable=1 for 3 cycles -> hit_cnt stays 16'hFFFF with no wrap-around.
REQ-033 Random {enable,in} for 1000 cycles -> d_q matches the previous cycle's d, d is one-hot or zero, and the number of 1s in d is at most 1 at all times.

Source files
------------

// File: rtl/dec_param_enable.sv
// dec_param_enable: parameterised N-to-2**N one-hot decoder with enable.
// The combinational decode d follows in/enable at all times (including
// during reset). A registered stage captures the decode one cycle later,
// together with a valid flag, the last enabled select index and a
// saturating count of enabled cycles.
//
// Qualifier semantics: valid_q is a registered copy of enable. When
// valid_q=1, d_q is the one-hot decode of sel_q; when valid_q=0, d_q is
// zero and sel_q holds the index of the most recent enabled cycle. There
// is no back-pressure: every edge with rst_n=1 produces a new sample.
module dec_param_enable #(
  parameter  int N = 2,
  localparam int W = 2**N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  input  logic         enable,
  output logic [W-1:0] d,
  output logic [W-1:0] d_q,
  output logic         valid_q,
  output logic [N-1:0] sel_q,
  output logic [15:0]  hit_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [W-1:0] w_d;
  logic         w_cnt_sat;
  logic [15:0]  w_cnt_next;

  logic [W-1:0] r_d_q;
  logic         r_valid_q;
  logic [N-1:0] r_sel_q;
  logic [15:0]  r_hit_cnt;

  // One-hot decode of the select index, forced to zero when disabled.
  always_comb begin
    w_d = '0;
    if (enable) begin
      w_d[in] = 1'b1;
    end
  end

  // Saturating next-count: stick at all-ones instead of wrapping.
  always_comb begin
    w_cnt_sat  = (r_hit_cnt == CNT_MAX);
    w_cnt_next = w_cnt_sat ? r_hit_cnt : (r_hit_cnt + 16'd1);
  end

  // Registered decode stage and valid flag; reset wins over any update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d_q     <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_d_q     <= w_d;
      r_valid_q <= enable;
    end
  end

  // Last select index seen while enabled; holds while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_q <= '0;
    end else if (enable) begin
      r_sel_q <= in;
    end
  end

  // Count of enabled cycles, saturating at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (enable) begin
      r_hit_cnt <= w_cnt_next;
    end
  end

  assign d       = w_d;
  assign d_q     = r_d_q;
  assign valid_q = r_valid_q;
  assign sel_q   = r_sel_q;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_dec_param_enable.sv
// Testbench for dec_param_enable (N=2): table sweep of the combinational
// decode, hand-written multi-cycle sequences, and randomized stimulus
// checked against a behavioural model plus an expected-value queue for d_q.
module tb_dec_param_enable;

  localparam int N = 2;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in;
  logic         enable;
  logic [W-1:0] d;
  logic [W-1:0] d_q;
  logic         valid_q;
  logic [N-1:0] sel_q;
  logic [15:0]  hit_cnt;

  always #5 clk = ~clk;

  dec_param_enable #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .enable  (enable),
    .d       (d),
    .d_q     (d_q),
    .valid_q (valid_q),
    .sel_q   (sel_q),
    .hit_cnt (hit_cnt)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  logic         m_valid;
  logic [N-1:0] m_sel;
  int           m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode expressed arithmetically: bit value 2**s when enabled.
  function automatic logic [W-1:0] model_decode(input logic en, input logic [N-1:0] s);
    int v;
    v = en ? (1 << int'(s)) : 0;
    return v[W-1:0];
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge. Applies inputs, checks d, clocks once, then
  // checks the registered outputs at the following negedge.
  task automatic step(input logic rn, input logic en, input logic [N-1:0] s, input bit do_chk);
    logic [W-1:0] ed;
    logic [W-1:0] eq;
    rst_n  = rn;
    enable = en;
    in     = s;
    ed = model_decode(en, s);
    #1;
    if (do_chk) begin
      chk("d", 32'(d), 32'(ed));
      chk("d_onehot_or_zero", 32'($countones(d) <= 1), 32'd1);
    end
    exp_q.push_back(rn ? ed : '0);
    @(posedge clk);
    if (!rn) begin
      m_valid = 1'b0;
      m_sel   = '0;
      m_cnt   = 0;
    end else begin
      m_valid = en;
      if (en) begin
        m_sel = s;
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      end
    end
    @(negedge clk);
    eq = exp_q.pop_front();
    if (do_chk) begin
      chk("d_q", 32'(d_q), 32'(eq));
      chk("valid_q", 32'(valid_q), 32'(m_valid));
      chk("sel_q", 32'(sel_q), 32'(m_sel));
      chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic         en;
    logic [N-1:0] s;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    m_valid = 1'b0;
    m_sel   = '0;
    m_cnt   = 0;
    rst_n   = 1'b0;
    enable  = 1'b0;
    in      = '0;

    vecs[0] = '{1'b0, 2'd0, 4'b0000};
    vecs[1] = '{1'b0, 2'd1, 4'b0000};
    vecs[2] = '{1'b0, 2'd2, 4'b0000};
    vecs[3] = '{1'b0, 2'd3, 4'b0000};
    vecs[4] = '{1'b1, 2'd0, 4'b0001};
    vecs[5] = '{1'b1, 2'd1, 4'b0010};
    vecs[6] = '{1'b1, 2'd2, 4'b0100};
    vecs[7] = '{1'b1, 2'd3, 4'b1000};

    @(negedge clk);

    // Combinational sweep of {enable,in} while reset is held.
    foreach (vecs[i]) begin
      enable = vecs[i].en;
      in     = vecs[i].s;
      #1;
      chk($sformatf("sweep_d[%0d]", i), 32'(d), 32'(vecs[i].exp_d));
    end
    @(negedge clk);

    // Reset held for two cycles, then one enabled cycle with in=2.
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    chk("reset_d_q", 32'(d_q), 32'd0);
    chk("reset_hit_cnt", 32'(hit_cnt), 32'd0);
    step(1'b1, 1'b1, 2'd2, 1'b1);
    chk("first_d_q", 32'(d_q), 32'b0100);
    chk("first_valid_q", 32'(valid_q), 32'd1);
    chk("first_sel_q", 32'(sel_q), 32'd2);
    chk("first_hit_cnt", 32'(hit_cnt), 32'd1);

    // Five enabled cycles at in=3, then three disabled cycles at in=1.
    step(1'b0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd1, 1'b1);
    chk("hold_hit_cnt", 32'(hit_cnt), 32'd5);
    chk("hold_sel_q", 32'(sel_q), 32'd3);
    chk("hold_d_q", 32'(d_q), 32'd0);
    chk("hold_valid_q", 32'(valid_q), 32'd0);
    chk("hold_d", 32'(d), 32'd0);

    // Reset asserted together with enable=1, in=1.
    step(1'b0, 1'b1, 2'd1, 1'b1);
    chk("rst_pri_d_q", 32'(d_q), 32'd0);
    chk("rst_pri_valid_q", 32'(valid_q), 32'd0);
    chk("rst_pri_sel_q", 32'(sel_q), 32'd0);
    chk("rst_pri_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_pri_d", 32'(d), 32'b0010);

    // Run the counter to 16'hFFFE, then three more enabled cycles.
    for (int i = 0; i < 65534; i++) step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
    chk("cnt_fffe", 32'(hit_cnt), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b1);
    chk("cnt_saturate", 32'(hit_cnt), 32'h0000FFFF);
    step(1'b1, 1'b0, 2'd2, 1'b1);
    chk("cnt_sat_hold", 32'(hit_cnt), 32'h0000FFFF);

    // Randomized stimulus with occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'b1);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
